// File: rtl/arbiter_rr_nch.sv
// Round-robin merge of NUM_SLV slave streams into one tagged FIFO write stream; 1-cycle accept-to-output latency.
// fifo_full/mstr_cmplt drop slv_ready in the same cycle and hold the grant; no beat is lost or duplicated.
module arbiter_rr_nch #(
  parameter  int NUM_SLV  = 4,
  parameter  int DW       = 32,
  parameter  int MODE_W   = 2,
  parameter  int PV_W     = 8,
  parameter  int HOLD_MAX = 16,
  localparam int SRC_W    = $clog2(NUM_SLV)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SLV*MODE_W-1:0] slv_mode,
  input  logic [NUM_SLV-1:0]        slv_data_valid,
  input  logic [NUM_SLV*DW-1:0]     slv_data,
  input  logic [NUM_SLV*PV_W-1:0]   slv_proc_val,
  output logic [NUM_SLV-1:0]        slv_ready,
  input  logic                      fifo_full,
  input  logic                      mstr_cmplt,
  output logic [MODE_W-1:0]         slvx_mode,
  output logic [DW-1:0]             slvx_data,
  output logic [PV_W-1:0]           slvx_proc_val,
  output logic                      slvx_data_valid,
  output logic [SRC_W-1:0]          data_source,
  output logic                      grant_active
);

  localparam int                CNT_W     = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]  HOLD_CAP  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [SRC_W-1:0]  LAST_CH   = SRC_W'(NUM_SLV - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SRC_W-1:0]         r_gnt;
  logic [SRC_W-1:0]         r_last_gnt;
  logic [CNT_W-1:0]         r_beat_cnt;

  logic [NUM_SLV-1:0]       w_req;
  logic                     w_any_req;
  logic [SRC_W-1:0]         w_rr_base;
  logic [2*NUM_SLV-1:0]     w_req2;
  logic [2*NUM_SLV-1:0]     w_req_shift;
  logic [NUM_SLV-1:0]       w_rot;
  logic [SRC_W-1:0]         w_pick;

  logic [MODE_W-1:0]        w_g_mode;
  logic [DW-1:0]            w_g_data;
  logic [PV_W-1:0]          w_g_pv;
  logic                     w_g_vld;

  logic                     w_stall;
  logic                     w_xfer;
  logic                     w_release;
  logic                     w_arb;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_req[i] = |slv_mode[i*MODE_W +: MODE_W];
    end
  end

  assign w_any_req = |w_req;

  // Search starts one past the last owner: rotate the doubled request vector so bit 0 is that channel.
  assign w_rr_base   = (r_last_gnt == LAST_CH) ? '0 : r_last_gnt + 1'b1;
  assign w_req2      = {w_req, w_req};
  assign w_req_shift = w_req2 >> w_rr_base;
  assign w_rot       = w_req_shift[NUM_SLV-1:0];

  always_comb begin
    w_pick = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pick = SRC_W'((int'(w_rr_base) + k) % NUM_SLV);
      end
    end
  end

  always_comb begin
    w_g_mode = '0;
    w_g_data = '0;
    w_g_pv   = '0;
    w_g_vld  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_gnt == SRC_W'(i)) begin
        w_g_mode = slv_mode[i*MODE_W +: MODE_W];
        w_g_data = slv_data[i*DW +: DW];
        w_g_pv   = slv_proc_val[i*PV_W +: PV_W];
        w_g_vld  = slv_data_valid[i];
      end
    end
  end

  // Ready is gated by rst so a beat presented during reset is never handshaken.
  assign w_stall   = fifo_full | mstr_cmplt;
  assign w_xfer    = (r_state == S_GRANT) & ~w_stall & ~rst & w_g_vld;
  assign w_release = (r_state == S_GRANT) &
                     ((w_g_mode == '0) ||
                      ((HOLD_MAX != 0) && w_xfer && (r_beat_cnt == HOLD_LAST)));

  always_comb begin
    slv_ready = '0;
    if ((r_state == S_GRANT) && !w_stall && !rst) begin
      slv_ready = NUM_SLV'(1) << r_gnt;
    end
  end

  assign grant_active = (r_state == S_GRANT);

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_GRANT;
          w_arb       = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter saturates at HOLD_MAX and is cleared only when a new grant is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_last_gnt <= LAST_CH;
      r_beat_cnt <= '0;
    end else begin
      if (w_arb) begin
        r_gnt      <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_xfer && (r_beat_cnt != HOLD_CAP)) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) begin
        r_last_gnt <= r_gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slvx_data_valid <= 1'b0;
      slvx_mode       <= '0;
      slvx_data       <= '0;
      slvx_proc_val   <= '0;
      data_source     <= '0;
    end else begin
      slvx_data_valid <= w_xfer;
      if (w_xfer) begin
        slvx_mode     <= w_g_mode;
        slvx_data     <= w_g_data;
        slvx_proc_val <= w_g_pv;
        data_source   <= r_gnt;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_nch.sv
// Directed bench for arbiter_rr_nch with a cycle model of the arbitration rules checked every cycle.
module tb_arbiter_rr_nch;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MW = 2;
  localparam int PW = 8;
  localparam int HM = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*MW-1:0] slv_mode;
  logic [N-1:0]    slv_data_valid;
  logic [N*DW-1:0] slv_data;
  logic [N*PW-1:0] slv_proc_val;
  logic [N-1:0]    slv_ready;
  logic            fifo_full;
  logic            mstr_cmplt;
  logic [MW-1:0]   slvx_mode;
  logic [DW-1:0]   slvx_data;
  logic [PW-1:0]   slvx_proc_val;
  logic            slvx_data_valid;
  logic [SW-1:0]   data_source;
  logic            grant_active;

  logic [MW-1:0]   s_mode [N];
  logic [DW-1:0]   s_dat  [N];
  logic [PW-1:0]   s_pv   [N];

  int n_assert = 0;
  int n_fail   = 0;

  arbiter_rr_nch #(.NUM_SLV(N), .DW(DW), .MODE_W(MW), .PV_W(PW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
    .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
    .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt), .slvx_mode(slvx_mode),
    .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
    .slvx_data_valid(slvx_data_valid), .data_source(data_source),
    .grant_active(grant_active)
  );

  always #5 clk = ~clk;

  always_comb begin
    slv_mode     = '0;
    slv_data     = '0;
    slv_proc_val = '0;
    for (int i = 0; i < N; i++) begin
      slv_mode[i*MW +: MW]     = s_mode[i];
      slv_data[i*DW +: DW]     = s_dat[i];
      slv_proc_val[i*PW +: PW] = s_pv[i];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner = channel currently holding the grant (-1 when none).
  int            m_owner;
  int            m_last;
  int            m_beats;
  bit            m_took;
  bit            chk_en = 1'b0;
  logic          e_vld;
  logic [DW-1:0] e_data;
  logic [MW-1:0] e_mode;
  logic [PW-1:0] e_pv;
  logic [SW-1:0] e_src;
  logic [N-1:0]  exp_rdy;

  function automatic logic [MW-1:0] mode_of(input int c);
    return slv_mode[c*MW +: MW];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_beats = 0;
      e_vld = 1'b0; e_data = '0; e_mode = '0; e_pv = '0; e_src = '0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      e_vld = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && mode_of((m_last + k) % N) != 0) begin
            m_owner = (m_last + k) % N;
            m_beats = 0;
          end
        end
      end else begin
        m_took = !(fifo_full || mstr_cmplt) && slv_data_valid[m_owner];
        if (m_took) begin
          e_vld  = 1'b1;
          e_data = slv_data[m_owner*DW +: DW];
          e_mode = slv_mode[m_owner*MW +: MW];
          e_pv   = slv_proc_val[m_owner*PW +: PW];
          e_src  = SW'(m_owner);
          m_beats++;
        end
        if (mode_of(m_owner) == 0 || (m_took && m_beats == HM)) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = (!rst && m_owner >= 0 && !fifo_full && !mstr_cmplt) ? (N'(1) << m_owner) : '0;
      check("m_ready", slv_ready, exp_rdy);
      check("m_vld", slvx_data_valid, e_vld);
      check("m_gact", grant_active, m_owner >= 0);
      check("m_data", slvx_data, e_data);
      check("m_mode", slvx_mode, e_mode);
      check("m_pv", slvx_proc_val, e_pv);
      check("m_src", data_source, e_src);
    end
  end

  // Bench-side slave handshake tracking and output pulse recording.
  logic [N-1:0]  acc_q = '0;
  int            q_src[$];
  logic [DW-1:0] q_dat[$];

  always @(negedge clk) begin
    acc_q = slv_ready & slv_data_valid;
    if (slvx_data_valid === 1'b1) begin
      q_src.push_back(int'(data_source));
      q_dat.push_back(slvx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_q[i]) s_dat[i] = s_dat[i] + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_src.delete();
    q_dat.delete();
  endtask

  task automatic set_only(input int ch, input logic [MW-1:0] md, input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) s_mode[i] = '0;
    s_mode[ch] = md;
    s_dat[ch]  = base;
  endtask

  task automatic check_stream(input string nm, input int src, input logic [DW-1:0] base, input int cnt);
    check({nm, "_count"}, q_dat.size(), cnt);
    for (int k = 0; k < cnt && k < q_dat.size(); k++) begin
      check({nm, "_data"}, q_dat[k], base + DW'(k));
      check({nm, "_src"}, q_src[k], src);
    end
  endtask

  int exp_src[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  bit found;

  initial begin
    rst = 1'b1; fifo_full = 1'b0; mstr_cmplt = 1'b0;
    slv_data_valid = '1;
    for (int i = 0; i < N; i++) begin
      s_mode[i] = 2'd1;
      s_dat[i]  = DW'(i + 1) << 28;
      s_pv[i]   = PW'(8'h10 + i);
    end

    // Reset with every channel requesting, then channel 0 first.
    tick(); tick();
    #2;
    check("t1_rst_ready", slv_ready, 4'b0000);
    check("t1_rst_vld", slvx_data_valid, 1'b0);
    check("t1_rst_gact", grant_active, 1'b0);
    check("t1_rst_data", slvx_data, 32'h0);
    check("t1_rst_src", data_source, 2'd0);
    rst = 1'b0;
    q_src.delete(); q_dat.delete();
    tick();
    #2;
    check("t1_first_ready", slv_ready, 4'b0001);

    // Rotation with a two-beat hold limit.
    for (int t = 0; t < 15; t++) tick();
    check("t2_pulses", q_src.size() >= 9, 1'b1);
    for (int k = 0; k < 9 && k < q_src.size(); k++) check("t2_src_seq", q_src[k], exp_src[k]);
    if (q_dat.size() >= 2) begin
      check("t2_ch0_beat0", q_dat[0], 32'h1000_0000);
      check("t2_ch0_beat1", q_dat[1], 32'h1000_0001);
    end

    // fifo_full for three cycles in the middle of a ch1 stream.
    set_only(1, 2'd1, 32'hA5A5_0001);
    do_reset();
    for (int t = 0; t < 4; t++) tick();
    fifo_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #2;
      check("t3_stall_ready", slv_ready, 4'b0000);
      if (j > 0) check("t3_stall_vld", slvx_data_valid, 1'b0);
      tick();
    end
    fifo_full = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    s_mode[1] = '0;
    tick(); tick();
    check_stream("t3", 1, 32'hA5A5_0001, 8);

    // ch2 drops mode together with its fifth beat; ch3 requests afterwards.
    set_only(2, 2'd1, 32'h0000_2001);
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (slv_ready[2] && s_dat[2] == 32'h0000_2005) begin
        s_mode[2] = '0;
        s_mode[3] = 2'd1;
        s_dat[3]  = 32'h0000_3001;
        found = 1'b1;
      end
    end
    check("t4_fifth_beat_seen", found, 1'b1);
    for (int t = 0; t < 6; t++) tick();
    s_mode[3] = '0;
    check("t4_pulses", q_src.size() >= 6, 1'b1);
    for (int k = 0; k < 5 && k < q_src.size(); k++) begin
      check("t4_src", q_src[k], 2);
      check("t4_data", q_dat[k], 32'h0000_2001 + DW'(k));
    end
    if (q_src.size() >= 6) check("t4_next_src", q_src[5], 3);
    tick(); tick();

    // mstr_cmplt during a ch3 grant.
    set_only(3, 2'd2, 32'h3000_0001);
    do_reset();
    tick(); tick();
    mstr_cmplt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #2;
      check("t5_stall_ready", slv_ready, 4'b0000);
      check("t5_stall_gact", grant_active, 1'b1);
      tick();
    end
    mstr_cmplt = 1'b0;
    #2;
    check("t5_resume_ready", slv_ready, 4'b1000);
    for (int t = 0; t < 4; t++) tick();
    s_mode[3] = '0;
    tick(); tick();
    check_stream("t5", 3, 32'h3000_0001, 4);

    // Reset while ch1 presents its third beat.
    set_only(1, 2'd1, 32'h6000_0001);
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (slv_ready[1] && s_dat[1] == 32'h6000_0003) begin
        rst = 1'b1;
        s_mode[0] = 2'd1;
        found = 1'b1;
      end
    end
    check("t6_beat3_seen", found, 1'b1);
    tick();
    #2;
    check("t6_rst_vld", slvx_data_valid, 1'b0);
    check("t6_rst_data", slvx_data, 32'h0);
    check("t6_rst_src", data_source, 2'd0);
    check("t6_rst_gact", grant_active, 1'b0);
    check("t6_rst_ready", slv_ready, 4'b0000);
    check("t6_discarded", s_dat[1], 32'h6000_0003);
    rst = 1'b0;
    tick();
    #2;
    check("t6_regrant_ch0", slv_ready, 4'b0001);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
